// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding, default sizes and operand pair type for the multiplier issuer
package mult_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_CW      = 8;
    localparam int DEF_TIMEOUT = 64;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } opnd_t;
endpackage

// File: rtl/mult_req_fifo.sv
// mult_req_fifo: DEPTH-entry synchronous FIFO with count-based full/empty
module mult_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    // pointers wrap naturally since DEPTH is a power of two; count separates full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mult_issuer.sv
// mult_issuer: queues operand pairs, issues them to a valid/done multiplier and returns product, latency and timeout
module mult_issuer import mult_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 4,
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MIN_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_opA,
    output logic [WIDTH-1:0] m_opB,
    input  logic             m_done,
    input  logic [WIDTH-1:0] m_product,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_product,
    output logic [CW-1:0]    res_cycles,
    output logic             res_timeout,
    output logic             busy
);
    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_inc;
    logic [2*WIDTH-1:0]      head;
    logic [$clog2(DEPTH):0]  count;
    logic                    full, empty, pop, done_ok, tmo;

    mult_req_fifo #(.DEPTH(DEPTH), .W(2*WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .pop   (pop),
        .din   ({req_a, req_b}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign req_ready = !full;
    assign pop       = state == IDLE && !empty;
    assign m_valid   = state == ISSUE;
    assign res_valid = state == RESP;
    assign busy      = count != '0 || state != IDLE;
    assign cnt_inc   = cnt + 1'b1;
    assign done_ok   = m_done && cnt >= CW'(MIN_LAT);
    assign tmo       = cnt_inc == CW'(TIMEOUT);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end

    // next state: done beats a coincident timeout since both lead to RESP and the datapath prefers done
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!empty) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (done_ok || tmo) state_nx = RESP;
            RESP:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand latch, latency counter and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_opA       <= '0;
            m_opB       <= '0;
            cnt         <= '0;
            res_product <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (pop) {m_opA, m_opB} <= head;
            if (state == ISSUE) cnt <= '0;
            else if (state == WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt_inc;
            if (state == WAIT && done_ok) begin
                res_product <= m_product;
                res_cycles  <= cnt_inc;
                res_timeout <= 1'b0;
            end else if (state == WAIT && tmo) begin
                res_product <= '0;
                res_cycles  <= CW'(TIMEOUT);
                res_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_issuer.sv
// tb_mult_issuer: scoreboard bench driving mult_issuer against a behavioural multiplier with per-op latency
module tb_mult_issuer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        m_valid, m_done;
    logic [31:0] m_opA, m_opB, m_product;
    logic        res_valid, res_ready, res_timeout, busy;
    logic [31:0] res_product;
    logic [7:0]  res_cycles;

    typedef struct {logic [31:0] p; int c; bit t;} exp_t;
    typedef struct {int lat; bit stale;} mop_t;
    exp_t        exp_q[$];
    mop_t        lat_q[$];
    mop_t        cur;
    int          k;
    bit          active;
    logic [31:0] prod;
    int          n_chk = 0, n_fail = 0, pulses = 0;
    bit          hs_prev = 1'b0;

    mult_issuer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .m_valid(m_valid), .m_opA(m_opA), .m_opB(m_opB),
        .m_done(m_done), .m_product(m_product), .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product), .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // behavioural multiplier: lat==0 never completes; stale keeps done high through the first cycle after the pulse
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            k      <= 0;
        end else if (m_valid) begin
            if (lat_q.size() == 0) check("model_underflow", 1, 0);
            else cur <= lat_q.pop_front();
            k      <= 1;
            active <= 1'b1;
            prod   <= m_opA * m_opB;
        end else begin
            k <= k + 1;
        end
    end
    always_comb begin
        m_done    = active && ((cur.lat != 0 && k >= cur.lat) || (cur.stale && k == 1));
        m_product = prod;
    end

    // monitor: counts pulses, checks results in order and no issue right after a handshake
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) hs_prev = 1'b0;
        else begin
            if (m_valid) pulses++;
            if (hs_prev) check("issue_after_handshake", m_valid, 0);
            hs_prev = res_valid && res_ready;
            if (hs_prev) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("res_product", res_product, e.p);
                    check("res_cycles", res_cycles, e.c);
                    check("res_timeout", res_timeout, e.t);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input int lat, input bit stale,
                        input logic [31:0] ep, input int ec, input bit et);
        bit ok;
        mop_t m;
        exp_t e;
        ok = 1'b0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) check("push_accept", 0, 1);
        else begin
            m.lat = lat; m.stale = stale;
            e.p = ep; e.c = ec; e.t = et;
            lat_q.push_back(m);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            ok = exp_q.size() == 0 && !busy;
        end
        if (!ok) check("drain", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [31:0] p0;
        logic [7:0]  c0;
        logic        t0;
        int          base;
        bit          ok;
        rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b1;
        cycles(2);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_opA", m_opA, 0);
        check("rst_m_opB", m_opB, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_product", res_product, 0);
        check("rst_res_cycles", res_cycles, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", req_ready, 1);
        cycles(1);

        push(32'h10001001, 32'h10010002, 5, 0, 32'h40012002, 5, 0);
        wait_drain(100);
        check("single_pulse_count", pulses, 1);

        res_ready = 1'b0;
        push(32'd3, 32'd7, 3, 0, 32'd21, 3, 0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        check("first_result_held", ok, 1);
        cycles(1);
        push(32'hFFFFFFFF, 32'd2, 2, 0, 32'hFFFFFFFE, 2, 0);
        push(32'h00010000, 32'h00010000, 6, 0, 32'h00000000, 6, 0);
        push(32'h0000FFFF, 32'h0000FFFF, 2, 0, 32'hFFFE0001, 2, 0);
        push(32'h80000000, 32'd3, 4, 0, 32'h80000000, 4, 0);
        @(negedge clk);
        check("full_req_ready", req_ready, 0);
        check("full_busy", busy, 1);
        p0 = res_product; c0 = res_cycles; t0 = res_timeout; base = pulses;
        check("held_product", p0, 21);
        cycles(1);
        fork
            push(32'd100, 32'd100, 2, 0, 32'h00002710, 2, 0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    check("bp_product", res_product, p0);
                    check("bp_cycles", res_cycles, c0);
                    check("bp_timeout", res_timeout, t0);
                    check("bp_req_ready", req_ready, 0);
                end
                check("bp_no_pulse", pulses, base);
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        wait_drain(300);

        push(32'd5, 32'd5, 0, 0, 32'd0, 64, 1);
        push(32'd6, 32'd7, 2, 0, 32'd42, 2, 0);
        push(32'd9, 32'd9, 4, 1, 32'd81, 4, 0);
        wait_drain(400);

        push(32'd1, 32'd1, 0, 0, 32'd1, 64, 1);
        push(32'd2, 32'd2, 0, 0, 32'd4, 64, 1);
        push(32'd3, 32'd3, 0, 0, 32'd9, 64, 1);
        cycles(4);
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("async_m_valid", m_valid, 0);
        check("async_m_opA", m_opA, 0);
        check("async_m_opB", m_opB, 0);
        check("async_res_valid", res_valid, 0);
        check("async_res_product", res_product, 0);
        check("async_res_cycles", res_cycles, 0);
        check("async_res_timeout", res_timeout, 0);
        check("async_busy", busy, 0);
        exp_q.delete();
        lat_q.delete();
        cycles(2);
        rst = 1'b1;
        base = pulses;
        cycles(10);
        check("post_reset_busy", busy, 0);
        check("post_reset_no_pulse", pulses, base);
        check("post_reset_req_ready", req_ready, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
